// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared single-port program/data memory.
// Data stage wins conflicts except when fetch has waited MAX_WAIT cycles.
module mem_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_stall,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        conflict_cnt
);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM_RD, OWN_DM_WR} owner_e;

  owner_e            owner_q, owner_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [7:0]        conflict_cnt_q, conflict_cnt_d;
  logic [DATA_W-1:0] if_hold_q, if_hold_d;
  logic [DATA_W-1:0] dm_hold_q, dm_hold_d;
  logic              if_gnt, dm_gnt, fetch_force;

  always_comb begin
    fetch_force = (wait_cnt_q == 4'(MAX_WAIT));
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    if (!rst) begin
      if (if_req && dm_req) begin
        if_gnt = fetch_force;
        dm_gnt = !fetch_force;
      end else begin
        if_gnt = if_req;
        dm_gnt = dm_req;
      end
    end
  end

  assign if_stall  = if_req & ~if_gnt & ~rst;
  assign dm_stall  = dm_req & ~dm_gnt & ~rst;
  assign mem_en    = if_gnt | dm_gnt;
  assign mem_we    = dm_gnt & dm_we;
  assign mem_addr  = if_gnt ? if_addr : (dm_gnt ? dm_addr : '0);
  assign mem_wdata = (dm_gnt & dm_we) ? dm_wdata : '0;

  // Return path is steered by who owned the memory on the previous cycle.
  assign if_valid     = (owner_q == OWN_IF);
  assign dm_valid     = (owner_q == OWN_DM_RD) || (owner_q == OWN_DM_WR);
  assign if_rdata     = (owner_q == OWN_IF)    ? mem_rdata : if_hold_q;
  assign dm_rdata     = (owner_q == OWN_DM_RD) ? mem_rdata : dm_hold_q;
  assign conflict_cnt = conflict_cnt_q;

  always_comb begin
    owner_d        = OWN_NONE;
    wait_cnt_d     = 4'd0;
    conflict_cnt_d = conflict_cnt_q;
    if_hold_d      = if_hold_q;
    dm_hold_d      = dm_hold_q;
    if (if_gnt)      owner_d = OWN_IF;
    else if (dm_gnt) owner_d = dm_we ? OWN_DM_WR : OWN_DM_RD;
    if (if_req && !if_gnt)
      wait_cnt_d = fetch_force ? wait_cnt_q : wait_cnt_q + 4'd1;
    if (if_req && dm_req && conflict_cnt_q != 8'hFF)
      conflict_cnt_d = conflict_cnt_q + 8'd1;
    if (owner_q == OWN_IF)    if_hold_d = mem_rdata;
    if (owner_q == OWN_DM_RD) dm_hold_d = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q        <= OWN_NONE;
      wait_cnt_q     <= 4'd0;
      conflict_cnt_q <= 8'd0;
      if_hold_q      <= '0;
      dm_hold_q      <= '0;
    end else begin
      owner_q        <= owner_d;
      wait_cnt_q     <= wait_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
      if_hold_q      <= if_hold_d;
      dm_hold_q      <= dm_hold_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter against a transaction-level
// model (grant rules, pending-return slot, shadow memory).
module tb_mem_port_arbiter;
  localparam int MAX_WAIT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [7:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic       if_stall, if_valid, dm_stall, dm_valid, mem_en, mem_we;
  logic [7:0] if_rdata, dm_rdata, mem_addr, mem_wdata, conflict_cnt;
  logic [7:0] mem_rdata = '0;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall), .if_valid(if_valid),
    .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_stall(dm_stall), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Memory seen by the DUT, and the model's own view of memory contents.
  logic [7:0] phys_mem [256];
  logic [7:0] ref_mem  [256];

  // Model state: fetch denial streak, one pending return, last delivered bytes.
  int         streak = 0, conf = 0;
  int         pend_kind = 0;  // 0 none, 1 fetch, 2 data read, 3 data write
  logic [7:0] pend_data = '0, if_last = '0, dm_last = '0;
  bit         g_if = 0, g_dm = 0, chk_en = 0;

  task automatic cyc(input bit r, input bit ir, input logic [7:0] ia,
                     input bit dr, input bit dw, input logic [7:0] da,
                     input logic [7:0] dd);
    bit         c_en, c_we;
    logic [7:0] c_a, c_d;
    bit         e_en, e_we;
    logic [7:0] e_a, e_d;
    rst = r; if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da;
    dm_wdata = dd;
    @(negedge clk);
    if (r) begin g_if = 0; g_dm = 0; end
    else if (ir && dr) begin g_if = (streak == MAX_WAIT); g_dm = !g_if; end
    else begin g_if = ir; g_dm = dr; end
    e_en = g_if || g_dm;
    e_we = g_dm && dw;
    e_a  = g_if ? ia : (g_dm ? da : 8'h00);
    e_d  = e_we ? dd : 8'h00;
    if (chk_en) begin
      chk("if_stall", if_stall, !r && ir && !g_if);
      chk("dm_stall", dm_stall, !r && dr && !g_dm);
      chk("mem_en", mem_en, e_en);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_a);
      chk("mem_wdata", mem_wdata, e_d);
      chk("if_valid", if_valid, pend_kind == 1);
      chk("dm_valid", dm_valid, pend_kind >= 2);
      chk("if_rdata", if_rdata, (pend_kind == 1) ? pend_data : if_last);
      chk("dm_rdata", dm_rdata, (pend_kind == 2) ? pend_data : dm_last);
      chk("conflict_cnt", conflict_cnt, conf);
    end
    c_en = mem_en; c_we = mem_we; c_a = mem_addr; c_d = mem_wdata;
    if (r) begin
      streak = 0; conf = 0; pend_kind = 0; if_last = 0; dm_last = 0;
    end else begin
      if (pend_kind == 1) if_last = pend_data;
      if (pend_kind == 2) dm_last = pend_data;
      if (ir && dr && conf < 255) conf++;
      streak = (ir && !g_if) ? ((streak < MAX_WAIT) ? streak + 1 : MAX_WAIT) : 0;
      pend_kind = 0;
      if (g_if) begin pend_kind = 1; pend_data = ref_mem[ia]; end
      else if (g_dm && dw) begin pend_kind = 3; ref_mem[da] = dd; end
      else if (g_dm) begin pend_kind = 2; pend_data = ref_mem[da]; end
    end
    @(posedge clk);
    #1;
    if (c_en) begin
      if (c_we) phys_mem[c_a] = c_d;
      else mem_rdata = phys_mem[c_a];
    end
    chk_en = 1;
  endtask

  initial begin
    logic [7:0] ia, da, dd;
    bit ir, dr, dw, r;
    for (int i = 0; i < 256; i++) begin
      phys_mem[i] = 8'($urandom);
      ref_mem[i]  = phys_mem[i];
    end
    phys_mem[1] = 8'h01; phys_mem[2] = 8'hC0; phys_mem[3] = 8'hC6; phys_mem[198] = 8'd39;
    ref_mem[1]  = 8'h01; ref_mem[2]  = 8'hC0; ref_mem[3]  = 8'hC6; ref_mem[198]  = 8'd39;
    #1;
    // reset with both requesting
    cyc(1, 1, 8'd5, 1, 0, 8'd6, 0);
    cyc(1, 1, 8'd5, 1, 0, 8'd6, 0);
    // fetch-only stream
    cyc(0, 1, 8'd1, 0, 0, 0, 0);
    cyc(0, 1, 8'd2, 0, 0, 0, 0);
    cyc(0, 1, 8'd3, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("fetch_last_byte", if_rdata, 8'hC6);
    // store then load
    cyc(0, 0, 0, 1, 1, 8'd200, 8'h14);
    cyc(0, 0, 0, 1, 0, 8'd200, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 8'd201, 8'h77);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("dm_rdata_after_ack", dm_rdata, 8'h14);
    // single conflict
    cyc(0, 1, 8'd4, 1, 0, 8'd198, 0);
    cyc(0, 1, 8'd4, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("conflict_once", conflict_cnt, 8'd1);
    chk("dm_rdata_198", dm_rdata, 8'd39);
    // same-address hazard: write wins, fetch then sees new value
    cyc(0, 1, 8'd50, 1, 1, 8'd50, 8'hA5);
    cyc(0, 1, 8'd50, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("fetch_after_write", if_rdata, 8'hA5);
    // starvation and saturation: both held for 320 cycles
    ia = 8'd10;
    for (int i = 0; i < 320; i++) begin
      cyc(0, 1, ia, 1, 0, 8'd198, 0);
      if (g_if) ia = ia + 8'd1;
    end
    chk("conflict_sat", conflict_cnt, 8'd255);
    // reset right after a fetch grant
    cyc(0, 1, 8'd2, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("conflict_after_rst", conflict_cnt, 8'd0);
    // random traffic; stalled requesters hold their command
    ir = 0; dr = 0; dw = 0; ia = 0; da = 0; dd = 0;
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(0, 79) == 0);
      if (!(ir && !g_if)) begin
        ir = ($urandom_range(0, 9) < 7);
        ia = 8'($urandom_range(0, 15));
      end
      if (!(dr && !g_dm)) begin
        dr = ($urandom_range(0, 9) < 6);
        dw = $urandom_range(0, 1) == 1;
        da = 8'($urandom_range(0, 15));
        dd = 8'($urandom);
      end
      cyc(r, ir, ia, dr, dw, da, dd);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port, 256-byte unified program/data memory between two requesters: the pipeline's instruction-fetch stage and the memory (load/store) stage.
- Grants one requester per cycle and stalls the loser.
- Tags each granted access so the 1-cycle-latency read data returns to the correct stage.
- Guarantees fetch progress with a starvation guard, and provides a saturating conflict counter for debug.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
MAX_WAIT, 4, consecutive denied fetch cycles after which fetch wins the next conflict; legal range 1..15

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
if_req  in  1  fetch read request
if_addr  in  ADDR_W  fetch address
if_stall  out  1  fetch request denied this cycle
if_valid  out  1  fetch read data valid (one cycle after grant)
if_rdata  out  DATA_W  fetch read data
dm_req  in  1  data-stage request
dm_we  in  1  1 = write, 0 = read
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_stall  out  1  data request denied this cycle
dm_valid  out  1  data read data valid, or write acknowledge (one cycle after grant)
dm_rdata  out  DATA_W  data read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe
conflict_cnt  out  8  cycles in which both requested; saturates at 255

Behaviour:
- Grant logic (combinational from current inputs and wait_cnt):
  - only one requester active: it is granted.
  - both active: dm is granted, unless wait_cnt == MAX_WAIT, in which case if is granted.
  - rst = 1: no grant.
- if_stall = if_req & ~if_gnt; dm_stall = dm_req & ~dm_gnt. Both are 0 when the corresponding req is 0.
- Memory command (combinational):
  - mem_en = if_gnt | dm_gnt.
  - mem_we = dm_gnt & dm_we.
  - mem_addr = address of the granted requester, else 0.
  - mem_wdata = dm_wdata when dm_gnt & dm_we, else 0.
- Owner register: owner <= {NONE, IF, DM_RD, DM_WR} per the grant this cycle; NONE when idle or during rst.
- Return path (cycle after grant):
  - if_valid = (owner == IF).
  - dm_valid = (owner == DM_RD) | (owner == DM_WR).
  - Valids are single-cycle pulses; back-to-back grants give back-to-back pulses.
- Read data:
  - if_rdata = mem_rdata when owner == IF, else a hold register (last delivered fetch byte).
  - dm_rdata = mem_rdata when owner == DM_RD, else a hold register.
  - Hold registers capture mem_rdata on the delivering cycle.
  - A write acknowledge does not change dm_rdata.
- Starvation counter wait_cnt (4 bits):
  - +1 when if_req & ~if_gnt, saturating at MAX_WAIT.
  - Cleared to 0 when if_gnt or ~if_req.
  - The forced fetch win lasts one cycle; wait_cnt is 0 afterward.
- conflict_cnt: +1 every cycle with if_req & dm_req & ~rst; holds at 255.
- Same-address ordering: conflicting requests are serialized in grant order. A fetch granted after a dm write to the same address reads the new value.
- Reset values (applied at the clock edge while rst = 1):
  - owner = NONE, wait_cnt = 0, conflict_cnt = 0, both hold registers = 0.
  - Hence if_valid = dm_valid = 0 and if_rdata = dm_rdata = 0.
  - While rst = 1: mem_en = mem_we = 0 and both stalls = 0.
- Reset mid-operation: a grant issued the cycle before rst rises still returns its valid in the rst cycle (owner was already registered). No grant is issued during rst, and no valid appears in the first cycle after rst falls.
- No internal queueing: a stalled requester must hold req, addr, we and wdata stable until it is granted.

Test Plan:
- Reset: rst = 1 for 2 cycles with both reqs high -> mem_en = 0, stalls = 0, valids = 0, rdata = 0, conflict_cnt = 0.
- Fetch only: if_req with if_addr = 1, 2, 3 on consecutive cycles, memory preloaded 01/C0/C6 -> if_valid high cycles 2-4, if_rdata = 01, C0, C6, if_stall never asserted.
- Store then load: dm write addr 200 data 20 (0x14), then dm read addr 200 -> mem_we pulses once, dm_valid in both following cycles, dm_rdata = 0x14 after the read and unchanged by the write ack.
- Conflict: if_req and dm_req (read addr 198 = 39) in the same cycle -> dm granted, if_stall = 1 for one cycle, fetch granted next cycle, conflict_cnt = 1, both valids pulse in successive cycles.
- Starvation: MAX_WAIT = 4, dm_req held continuously with if_req held -> dm granted 4 cycles, fetch granted in cycle 5 (dm_stall = 1 there), pattern repeats every 5 cycles.
- Saturation and mid-op reset: 300 conflict cycles -> conflict_cnt holds 255. Assert rst the cycle after a fetch grant -> if_valid still pulses in that rst cycle, then all state returns to reset values.
